// File: rtl/ms_tick_stopwatch_if.sv
// ----------------------------------------------------------------------------
// ms_tick_stopwatch_if
// Bundles the stopwatch control inputs and display outputs.
//   master : drives tick/start/stop/clear/lap, observes status and BCD value
//   slave  : the stopwatch itself
// Signals:
//   tick        1 ms pulse, one clk cycle wide
//   start/stop  run control, level sampled each clk
//   clear       zero count, lap snapshot and overflow
//   lap         lap toggle, rising edge detected inside the stopwatch
//   running     state is RUN
//   lap_active  displayed value is the frozen lap snapshot
//   overflow    sticky wrap flag
//   ms_bcd      3 BCD digits of milliseconds
//   sec_bcd     2 BCD digits of seconds
//   min_bcd     2 BCD digits of minutes
// ----------------------------------------------------------------------------
interface ms_tick_stopwatch_if;
    logic        tick;
    logic        start;
    logic        stop;
    logic        clear;
    logic        lap;
    logic        running;
    logic        lap_active;
    logic        overflow;
    logic [11:0] ms_bcd;
    logic [7:0]  sec_bcd;
    logic [7:0]  min_bcd;

    modport master (
        output tick, start, stop, clear, lap,
        input  running, lap_active, overflow, ms_bcd, sec_bcd, min_bcd
    );

    modport slave (
        input  tick, start, stop, clear, lap,
        output running, lap_active, overflow, ms_bcd, sec_bcd, min_bcd
    );
endinterface

// File: rtl/ms_tick_stopwatch.sv
// ----------------------------------------------------------------------------
// ms_tick_stopwatch
// Counts 1 ms tick pulses into a BCD mm:ss.mmm stopwatch with start/stop/clear
// control and a lap-freeze display.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    ms_tick_stopwatch_if.slave (control inputs, status and BCD outputs)
// Parameter:
//   MAX_MIN  last minute value before MAX_MIN:59.999 wraps to 00:00.000 (1..99)
//
// state   | meaning
// IDLE    | cleared / never started, ticks ignored
// RUN     | ticks are counted
// PAUSED  | count held, start resumes
// ----------------------------------------------------------------------------
module ms_tick_stopwatch #(
    parameter int MAX_MIN = 59
) (
    input logic               clk,
    input logic               reset,
    ms_tick_stopwatch_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;

    localparam logic [7:0] MIN_LAST = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    logic [1:0]  r_state;
    logic [11:0] r_ms;
    logic [7:0]  r_sec;
    logic [7:0]  r_min;
    logic [11:0] r_snap_ms;
    logic [7:0]  r_snap_sec;
    logic [7:0]  r_snap_min;
    logic        r_lap_active;
    logic        r_overflow;
    logic        r_lap_d;

    logic        w_count;
    logic        w_lap_edge;
    logic        w_wrap;
    logic [11:0] w_ms_nxt;
    logic [7:0]  w_sec_nxt;
    logic [7:0]  w_min_nxt;

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        logic [7:0] r;
        r[3:0] = digit_inc(v[3:0]);
        r[7:4] = (v[3:0] == 4'd9) ? digit_inc(v[7:4]) : v[7:4];
        return r;
    endfunction

    assign w_count    = (r_state == S_RUN) && bus.tick && !bus.clear;
    assign w_lap_edge = bus.lap && !r_lap_d;

    // Digit-wise BCD carry chain so no binary intermediate ever reaches a register.
    always_comb begin
        w_ms_nxt  = r_ms;
        w_sec_nxt = r_sec;
        w_min_nxt = r_min;
        w_wrap    = 1'b0;
        if (w_count) begin
            w_ms_nxt[3:0] = digit_inc(r_ms[3:0]);
            if (r_ms[3:0] == 4'd9) begin
                w_ms_nxt[7:4] = digit_inc(r_ms[7:4]);
                if (r_ms[7:4] == 4'd9) begin
                    w_ms_nxt[11:8] = digit_inc(r_ms[11:8]);
                end
            end
            if (r_ms == 12'h999) begin
                if (r_sec == 8'h59) begin
                    w_sec_nxt = 8'h00;
                    if (r_min == MIN_LAST) begin
                        w_min_nxt = 8'h00;
                        w_wrap    = 1'b1;
                    end else begin
                        w_min_nxt = bcd2_inc(r_min);
                    end
                end else begin
                    w_sec_nxt = bcd2_inc(r_sec);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ms         <= 12'h000;
            r_sec        <= 8'h00;
            r_min        <= 8'h00;
            r_snap_ms    <= 12'h000;
            r_snap_sec   <= 8'h00;
            r_snap_min   <= 8'h00;
            r_lap_active <= 1'b0;
            r_overflow   <= 1'b0;
            r_lap_d      <= 1'b0;
        end else begin
            r_lap_d <= bus.lap;
            if (bus.clear) begin
                r_state      <= S_IDLE;
                r_ms         <= 12'h000;
                r_sec        <= 8'h00;
                r_min        <= 8'h00;
                r_snap_ms    <= 12'h000;
                r_snap_sec   <= 8'h00;
                r_snap_min   <= 8'h00;
                r_lap_active <= 1'b0;
                r_overflow   <= 1'b0;
            end else begin
                r_ms  <= w_ms_nxt;
                r_sec <= w_sec_nxt;
                r_min <= w_min_nxt;
                if (w_wrap) begin
                    r_overflow <= 1'b1;
                end
                // Snapshot takes the post-increment value so a same-cycle tick is included.
                if (w_lap_edge && (r_state != S_IDLE)) begin
                    r_lap_active <= !r_lap_active;
                    if (!r_lap_active) begin
                        r_snap_ms  <= w_ms_nxt;
                        r_snap_sec <= w_sec_nxt;
                        r_snap_min <= w_min_nxt;
                    end
                end
                case (r_state)
                    S_IDLE:   if (bus.start && !bus.stop) r_state <= S_RUN;
                    S_RUN:    if (bus.stop) r_state <= S_PAUSED;
                    S_PAUSED: if (bus.start && !bus.stop) r_state <= S_RUN;
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.running    = (r_state == S_RUN);
    assign bus.lap_active = r_lap_active;
    assign bus.overflow   = r_overflow;
    assign bus.ms_bcd     = r_lap_active ? r_snap_ms  : r_ms;
    assign bus.sec_bcd    = r_lap_active ? r_snap_sec : r_sec;
    assign bus.min_bcd    = r_lap_active ? r_snap_min : r_min;

endmodule
